sockit_spi_ser_sync: RTL and testbench

Second-generation SPI master serializer/deserializer. It runs entirely in one system clock domain: SCLK is derived from a programmable divider, with no clock muxing. It is generalised to IOW data lanes (single/3-wire/dual/quad/octal), selectable bit order, and backpressure on the input queue. It sits between the command/output/input queues and the pad ring, replacing the dual-edge serializer.

---
 rtl/sockit_spi_pkg.sv | 41 ++++
 rtl/sockit_spi_ser_clkgen.sv | 40 ++++
 rtl/sockit_spi_ser_sync.sv | 176 +++++++++++++++++
 tb/tb_sockit_spi_ser_sync.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sockit_spi_pkg.sv
// rtl/sockit_spi_pkg.sv - shared types and helpers for the sockit SPI serializer
package sockit_spi_pkg;

    localparam int SER_SDL = 3;

    typedef enum logic [2:0] {
        IOM_3W   = 3'd0,
        IOM_SGL  = 3'd1,
        IOM_DUAL = 3'd2,
        IOM_QUAD = 3'd3,
        IOM_OCT  = 3'd4
    } iom_t;

    typedef struct packed {
        logic [SER_SDL-1:0] cnt;
        iom_t               iom;
        logic               doe;
        logic               die;
        logic               cke;
        logic               sso;
        logic               lst;
    } ser_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ser_state_t;

    // Lanes carrying data for a given mode; octal falls back to quad on narrow pads.
    function automatic logic [7:0] lane_mask(iom_t iom, int iow);
        case (iom)
            IOM_DUAL: return 8'h03;
            IOM_QUAD: return 8'h0F;
            IOM_OCT:  return (iow == 8) ? 8'hFF : 8'h0F;
            default:  return 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/sockit_spi_ser_clkgen.sv
// rtl/sockit_spi_ser_clkgen.sv - SCLK divider with leading/trailing edge strobes
module sockit_spi_ser_clkgen #(
    parameter int DVW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cke,
    input  logic [DVW-1:0] div,
    output logic           sclk_q,
    output logic           lead_stb,
    output logic           trail_stb,
    output logic           period_end
);

    logic [DVW-1:0] div_cnt;
    logic           half_q;
    logic           half_end;

    assign half_end   = en && (div_cnt == div);
    assign lead_stb   = half_end && !half_q;
    assign trail_stb  = half_end && half_q;
    assign period_end = trail_stb;

    // Strobes keep running with cke=0 so dummy periods are still counted.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            half_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            half_q  <= ~half_q;
            sclk_q  <= cke & ~half_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sockit_spi_ser_sync.sv
// rtl/sockit_spi_ser_sync.sv - single-clock multi-lane SPI master serializer
module sockit_spi_ser_sync
    import sockit_spi_pkg::*;
#(
    parameter int SSW = 8,
    parameter int SDW = 8,
    parameter int SDL = $clog2(SDW),
    parameter int IOW = 8,
    parameter int DVW = 8,
    parameter int QDW = IOW*SDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_pol,
    input  logic           cfg_pha,
    input  logic           cfg_lsb,
    input  logic [DVW-1:0] cfg_div,
    input  logic [SSW-1:0] cfg_sss,
    input  logic           cfg_coe,
    input  logic           cfg_soe,
    input  logic           quc_vld,
    output logic           quc_rdy,
    input  ser_cmd_t       quc_dat,
    input  logic           quo_vld,
    output logic           quo_rdy,
    input  logic [QDW-1:0] quo_dat,
    output logic           qui_vld,
    input  logic           qui_rdy,
    output logic [QDW-1:0] qui_dat,
    output logic           spi_sclk_o,
    output logic           spi_sclk_e,
    input  logic [IOW-1:0] spi_sio_i,
    output logic [IOW-1:0] spi_sio_o,
    output logic [IOW-1:0] spi_sio_e,
    output logic [SSW-1:0] spi_ss_o,
    output logic [SSW-1:0] spi_ss_e
);

    ser_state_t state_q, state_d;

    logic [SDL-1:0] cnt_q, bit_cnt_q;
    iom_t           iom_q;
    logic           doe_q, die_q, cke_q, lst_q;
    logic           pol_q, pha_q, lsb_q;
    logic [DVW-1:0] div_q;
    logic [SSW-1:0] sso_q;
    logic           run_q;
    logic [IOW-1:0] sio_e_q;
    logic [IOW-1:0][SDW-1:0] sdo_q, sdi_q, load_dat;

    logic           sclk_q, lead_stb, trail_stb, period_end;
    logic           sample, launch;
    logic [7:0]     mask8;
    logic [IOW-1:0] lane_en, in_bit, msb;

    sockit_spi_ser_clkgen #(.DVW(DVW)) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == SHIFT),
        .cke        (cke_q),
        .div        (div_q),
        .sclk_q     (sclk_q),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .period_end (period_end)
    );

    assign mask8   = lane_mask(iom_q, IOW);
    assign lane_en = mask8[IOW-1:0];

    // With pha=1 the first bit is preloaded, so the first leading edge does not shift.
    assign sample = pha_q ? trail_stb : lead_stb;
    assign launch = pha_q ? (lead_stb && bit_cnt_q != '0) : trail_stb;

    assign quc_rdy    = (state_q == IDLE) && run_q;
    assign quo_rdy    = (state_q == LOAD);
    assign qui_vld    = (state_q == DONE) && die_q;
    assign spi_sclk_o = ((state_q == IDLE) ? cfg_pol : pol_q) ^ sclk_q;
    assign spi_sclk_e = cfg_coe;
    assign spi_ss_o   = sso_q;
    assign spi_ss_e   = {SSW{cfg_soe}};
    assign spi_sio_e  = sio_e_q;
    assign spi_sio_o  = msb & sio_e_q;

    always_comb begin
        in_bit = spi_sio_i;
        if (iom_q == IOM_SGL) in_bit[0] = spi_sio_i[1];
        msb      = '0;
        qui_dat  = '0;
        load_dat = '0;
        for (int k = 0; k < IOW; k++) begin
            msb[k] = sdo_q[k][SDW-1];
            for (int j = 0; j < SDW; j++) begin
                qui_dat[k*SDW+j] = lane_en[k] & (lsb_q ? sdi_q[k][SDW-1-j] : sdi_q[k][j]);
                load_dat[k][j]   = lsb_q ? quo_dat[k*SDW+SDW-1-j] : quo_dat[k*SDW+j];
            end
        end
    end

    // DONE is entered after the trailing half of the last period so SCLK ends idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (quc_vld && quc_rdy) state_d = quc_dat.doe ? LOAD : SHIFT;
            LOAD:  if (quo_vld) state_d = SHIFT;
            SHIFT: if (period_end && bit_cnt_q == cnt_q) state_d = DONE;
            DONE:  if (!die_q || qui_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            iom_q     <= IOM_3W;
            doe_q     <= 1'b0;
            die_q     <= 1'b0;
            cke_q     <= 1'b0;
            lst_q     <= 1'b0;
            pol_q     <= 1'b0;
            pha_q     <= 1'b0;
            lsb_q     <= 1'b0;
            div_q     <= '0;
            sso_q     <= '0;
            sio_e_q   <= '0;
            sdo_q     <= '0;
            sdi_q     <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            case (state_q)
                IDLE: begin
                    sio_e_q <= '0;
                    if (quc_vld && quc_rdy) begin
                        cnt_q     <= quc_dat.cnt;
                        iom_q     <= quc_dat.iom;
                        doe_q     <= quc_dat.doe;
                        die_q     <= quc_dat.die;
                        cke_q     <= quc_dat.cke;
                        lst_q     <= quc_dat.lst;
                        pol_q     <= cfg_pol;
                        pha_q     <= cfg_pha;
                        lsb_q     <= cfg_lsb;
                        div_q     <= cfg_div;
                        sso_q     <= {SSW{quc_dat.sso}} & cfg_sss;
                        bit_cnt_q <= '0;
                        sdo_q     <= '0;
                        sdi_q     <= '0;
                    end
                end
                LOAD: begin
                    if (quo_vld) begin
                        sdo_q   <= load_dat;
                        sio_e_q <= lane_en & {IOW{doe_q}};
                    end
                end
                SHIFT: begin
                    for (int k = 0; k < IOW; k++) begin
                        if (launch) sdo_q[k] <= {sdo_q[k][SDW-2:0], 1'b0};
                        if (sample && die_q) sdi_q[k] <= {sdi_q[k][SDW-2:0], in_bit[k]};
                    end
                    if (period_end) bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (state_d == DONE) sio_e_q <= '0;
                end
                DONE: begin
                    if ((!die_q || qui_rdy) && lst_q) sso_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sockit_spi_ser_sync.sv
// tb/tb_sockit_spi_ser_sync.sv - directed self-checking bench for sockit_spi_ser_sync
module tb_sockit_spi_ser_sync;
    import sockit_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_pol, cfg_pha, cfg_lsb, cfg_coe, cfg_soe;
    logic [7:0]  cfg_div, cfg_sss;
    logic        quc_vld, quc_rdy, quo_vld, quo_rdy, qui_vld, qui_rdy;
    ser_cmd_t    quc_dat;
    logic [63:0] quo_dat, qui_dat;
    logic        spi_sclk_o, spi_sclk_e;
    logic [7:0]  spi_sio_i, spi_sio_o, spi_sio_e, spi_ss_o, spi_ss_e;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0, mon_tog, first_tc, last_tc, e_cnt, n;
    logic [7:0]  mon_bits;
    logic        mon_prev, ss_seen, ok;
    logic [63:0] snap;

    always #5 clk = ~clk;

    // sio1 follows sio0 so single mode loops back; other lanes loop to themselves.
    assign spi_sio_i = {spi_sio_o[7:2], spi_sio_o[0], spi_sio_o[0]};

    sockit_spi_ser_sync dut (
        .clk(clk), .rst(rst),
        .cfg_pol(cfg_pol), .cfg_pha(cfg_pha), .cfg_lsb(cfg_lsb), .cfg_div(cfg_div),
        .cfg_sss(cfg_sss), .cfg_coe(cfg_coe), .cfg_soe(cfg_soe),
        .quc_vld(quc_vld), .quc_rdy(quc_rdy), .quc_dat(quc_dat),
        .quo_vld(quo_vld), .quo_rdy(quo_rdy), .quo_dat(quo_dat),
        .qui_vld(qui_vld), .qui_rdy(qui_rdy), .qui_dat(qui_dat),
        .spi_sclk_o(spi_sclk_o), .spi_sclk_e(spi_sclk_e),
        .spi_sio_i(spi_sio_i), .spi_sio_o(spi_sio_o), .spi_sio_e(spi_sio_e),
        .spi_ss_o(spi_ss_o), .spi_ss_e(spi_ss_e)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ser_cmd_t mk_cmd(input logic [2:0] cnt, input iom_t iom, input logic doe,
                                        input logic die, input logic cke, input logic sso,
                                        input logic lst);
        ser_cmd_t c;
        c.cnt = cnt; c.iom = iom; c.doe = doe; c.die = die;
        c.cke = cke; c.sso = sso; c.lst = lst;
        return c;
    endfunction

    // Sample level of SCLK after a sampling edge: rising for modes 0/3, falling for 1/2.
    always @(negedge clk) begin
        cyc++;
        if (spi_sclk_o != mon_prev) begin
            mon_tog++;
            if (first_tc < 0) first_tc = cyc;
            last_tc = cyc;
            if (spi_sclk_o == ~(cfg_pol ^ cfg_pha)) mon_bits = {mon_bits[6:0], spi_sio_o[0]};
        end
        if (spi_ss_o != 8'h00) ss_seen = 1'b1;
        if (spi_sio_e == 8'hFF) e_cnt++;
        mon_prev = spi_sclk_o;
    end

    task automatic mon_start();
        mon_tog = 0; first_tc = -1; last_tc = -1; e_cnt = 0;
        mon_bits = '0; ss_seen = 1'b0; mon_prev = spi_sclk_o;
    endtask

    task automatic send_cmd(input ser_cmd_t c);
        int k = 0;
        @(negedge clk);
        quc_dat = c; quc_vld = 1'b1;
        while (!quc_rdy && k < 200) begin @(negedge clk); k++; end
        chk("cmd_accept", quc_rdy, 1);
        @(posedge clk); #1;
        quc_vld = 1'b0;
    endtask

    task automatic send_dat(input logic [63:0] d);
        int k = 0;
        @(negedge clk);
        quo_dat = d; quo_vld = 1'b1;
        while (!quo_rdy && k < 200) begin @(negedge clk); k++; end
        chk("dat_accept", quo_rdy, 1);
        @(posedge clk); #1;
        quo_vld = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int k = 0;
        while (!qui_vld && k < 500) begin @(negedge clk); k++; end
        chk(tag, qui_vld, 1);
    endtask

    task automatic ack();
        @(negedge clk); qui_rdy = 1'b1;
        @(posedge clk); #1; qui_rdy = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, output int cnt);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!quc_rdy && cnt < 500);
        chk(tag, quc_rdy, 1);
    endtask

    initial begin
        rst = 1'b1; cfg_pol = 0; cfg_pha = 0; cfg_lsb = 0; cfg_div = 0;
        cfg_sss = 8'h05; cfg_coe = 1; cfg_soe = 1;
        quc_vld = 0; quc_dat = '0; quo_vld = 0; quo_dat = '0; qui_rdy = 0;
        mon_start();
        repeat (3) @(negedge clk);
        chk("rst_quc_rdy", quc_rdy, 0);
        chk("rst_quo_rdy", quo_rdy, 0);
        chk("rst_qui_vld", qui_vld, 0);
        chk("rst_qui_dat", qui_dat, 0);
        chk("rst_sio_e", spi_sio_e, 0);
        chk("rst_sio_o", spi_sio_o, 0);
        chk("rst_ss_o", spi_ss_o, 0);
        chk("rst_sclk", spi_sclk_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_quc_rdy", quc_rdy, 1);
        chk("sclk_e", spi_sclk_e, 1);
        chk("ss_e", spi_ss_e, 8'hFF);

        // mode 0, single lane, 0xA5 looped back
        mon_start();
        send_cmd(mk_cmd(3'd7, IOM_SGL, 1, 1, 1, 1, 1));
        send_dat(64'h0000_0000_0000_00A5);
        wait_vld("t1_vld");
        chk("t1_qui", qui_dat, 64'hA5);
        ack();
        wait_rdy("t1_rdy", n);
        chk("t1_tog", mon_tog, 16);
        chk("t1_bits", mon_bits, 8'hA5);
        chk("t1_span", last_tc - first_tc, 15);
        chk("t1_ss_seen", ss_seen, 1);
        chk("t1_ss_off", spi_ss_o, 0);

        // mode 3, LSB-first, div=3
        cfg_pol = 1; cfg_pha = 1; cfg_lsb = 1; cfg_div = 8'd3;
        @(negedge clk);
        chk("t2_idle_hi", spi_sclk_o, 1);
        mon_start();
        send_cmd(mk_cmd(3'd7, IOM_SGL, 1, 1, 1, 1, 1));
        send_dat(64'h0000_0000_0000_0001);
        wait_vld("t2_vld");
        chk("t2_qui", qui_dat, 64'h01);
        ack();
        wait_rdy("t2_rdy", n);
        chk("t2_tog", mon_tog, 16);
        chk("t2_bits", mon_bits, 8'h80);
        chk("t2_span", last_tc - first_tc, 60);
        chk("t2_end_hi", spi_sclk_o, 1);

        // octal, one period
        cfg_pol = 0; cfg_pha = 0; cfg_lsb = 0; cfg_div = 8'd0;
        @(negedge clk);
        mon_start();
        send_cmd(mk_cmd(3'd0, IOM_OCT, 1, 0, 1, 1, 1));
        send_dat(64'h0102_0408_1020_4080);
        n = 0;
        while (spi_sio_e == 8'h00 && n < 50) begin @(negedge clk); n++; end
        chk("t3_sio_e", spi_sio_e, 8'hFF);
        chk("t3_sio_o", spi_sio_o, 8'h01);
        wait_rdy("t3_rdy", n);
        chk("t3_tog", mon_tog, 2);
        chk("t3_e_cnt", e_cnt, 2);

        // input stall: qui_rdy low for 10 clk, lst=0
        mon_start();
        send_cmd(mk_cmd(3'd7, IOM_SGL, 1, 1, 1, 1, 0));
        send_dat(64'hFFFF_FFFF_FFFF_FF3C);
        wait_vld("t4_vld");
        snap = qui_dat;
        chk("t4_qui", qui_dat, 64'h3C);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (qui_dat !== snap || spi_sclk_o !== 1'b0 || quc_rdy !== 1'b0 || qui_vld !== 1'b1)
                ok = 1'b0;
        end
        chk("t4_hold", ok, 1);
        ack();
        @(negedge clk);
        chk("t4_quc_rdy", quc_rdy, 1);
        chk("t4_qui_vld", qui_vld, 0);
        chk("t4_ss_kept", spi_ss_o, 8'h05);

        // cke=0 dummy periods: 4 x 4 clk in SHIFT, one DONE, then IDLE
        cfg_div = 8'd1;
        @(negedge clk);
        mon_start();
        send_cmd(mk_cmd(3'd3, IOM_SGL, 0, 0, 0, 1, 0));
        n = 0; ok = 1'b1;
        do begin
            @(negedge clk); n++;
            if (spi_ss_o !== 8'h05) ok = 1'b0;
        end while (!quc_rdy && n < 200);
        chk("t5_cycles", n, 18);
        chk("t5_ss_held", ok, 1);
        chk("t5_tog", mon_tog, 0);

        // reset mid quad transfer
        cfg_pol = 1; cfg_div = 8'd2;
        send_cmd(mk_cmd(3'd7, IOM_QUAD, 1, 1, 1, 1, 1));
        send_dat(64'h0000_0000_1234_5678);
        n = 0;
        while (spi_sio_e == 8'h00 && n < 50) begin @(negedge clk); n++; end
        chk("t6_sio_e", spi_sio_e, 8'h0F);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_sio_e_rst", spi_sio_e, 0);
        chk("t6_ss_rst", spi_ss_o, 0);
        chk("t6_sclk_rst", spi_sclk_o, 1);
        chk("t6_vld_rst", qui_vld, 0);
        chk("t6_quo_rdy_rst", quo_rdy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_quc_rdy", quc_rdy, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
